// File: rtl/ysyx_040066_bus_pkg.sv
// Shared bus types for the memory arbiter: burst length codes, FSM states and the latched command.
package ysyx_040066_bus_pkg;

    localparam logic [2:0] LEN_1 = 3'd0;
    localparam logic [2:0] LEN_2 = 3'd1;
    localparam logic [2:0] LEN_4 = 3'd3;
    localparam logic [2:0] LEN_8 = 3'd7;

    // Widest address/line the command buffer can carry; narrower instances use the low bits.
    localparam int CMD_ADDR_W = 64;
    localparam int CMD_LINE_W = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_RD = 2'd1,
        BUSY_WR = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  wen;
        logic                  burst;
        logic [2:0]            len;
        logic [7:0]            mask;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LINE_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ysyx_040066_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping to 0.
module ysyx_040066_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    int w_j;

    // Scan offsets high to low so the closest requester to i_ptr is written last.
    always_comb begin
        o_vld = |i_req;
        o_idx = '0;
        w_j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (i_req[w_j]) o_idx = IDX_W'(w_j);
        end
    end

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// N-master round-robin arbiter onto one read and one write port; grant locked to completion or timeout.
// Request to downstream req is 1 cycle; responses route back combinationally; one IDLE cycle between grants.
module ysyx_040066_mem_arbiter
    import ysyx_040066_bus_pkg::*;
#(
    parameter int N_MST   = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
    parameter int IDX_W   = $clog2(N_MST)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MST-1:0]        m_req,
    input  logic [N_MST-1:0]        m_wen,
    input  logic [N_MST-1:0]        m_burst,
    input  logic [3*N_MST-1:0]      m_len,
    input  logic [8*N_MST-1:0]      m_mask,
    input  logic [ADDR_W*N_MST-1:0] m_addr,
    input  logic [LINE_W*N_MST-1:0] m_wdata,
    output logic [N_MST-1:0]        m_ready,
    output logic [N_MST-1:0]        m_err,
    output logic [N_MST-1:0]        m_last,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    rd_req,
    output logic                    rd_burst,
    output logic [2:0]              rd_len,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_ready,
    input  logic                    rd_err,
    input  logic                    rd_last,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    wr_req,
    output logic                    wr_burst,
    output logic [2:0]              wr_len,
    output logic [7:0]              wr_mask,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LINE_W-1:0]       wr_data,
    input  logic                    wr_ready,
    input  logic                    wr_err,
    output logic [IDX_W-1:0]        gnt_idx
);

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    arb_state_e       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [TO_W-1:0]  r_wdog;
    cmd_t             r_cmd;

    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick_idx;
    cmd_t             w_pick_cmd;
    logic             w_busy_rd;
    logic             w_busy_wr;
    logic             w_act_rdy;
    logic             w_to;
    logic             w_done;
    logic             w_rsp_rdy;
    logic             w_rsp_err;
    logic             w_rsp_last;
    logic [IDX_W-1:0] w_next_ptr;

    ysyx_040066_rr_pick #(
        .N     (N_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (m_req),
        .i_ptr (r_rr_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    always_comb begin
        w_pick_cmd       = '0;
        w_pick_cmd.wen   = m_wen[w_pick_idx];
        w_pick_cmd.burst = m_burst[w_pick_idx];
        w_pick_cmd.len   = m_len[w_pick_idx*3 +: 3];
        w_pick_cmd.mask  = m_mask[w_pick_idx*8 +: 8];
        w_pick_cmd.addr  = CMD_ADDR_W'(m_addr[w_pick_idx*ADDR_W +: ADDR_W]);
        w_pick_cmd.wdata = CMD_LINE_W'(m_wdata[w_pick_idx*LINE_W +: LINE_W]);
    end

    assign w_busy_rd  = (r_state == BUSY_RD);
    assign w_busy_wr  = (r_state == BUSY_WR);
    assign w_act_rdy  = (w_busy_rd && rd_ready) || (w_busy_wr && wr_ready);
    // A ready beat in the timeout cycle suppresses the timeout.
    assign w_to       = (TIMEOUT > 0) && (w_busy_rd || w_busy_wr) && !w_act_rdy && (r_wdog == TO_VAL);
    assign w_done     = w_to || (w_busy_rd && rd_ready && (rd_last || rd_err)) || (w_busy_wr && wr_ready);
    assign w_next_ptr = (r_gnt_idx == IDX_W'(N_MST - 1)) ? '0 : r_gnt_idx + 1'b1;

    always_comb begin
        w_rsp_rdy  = w_act_rdy || w_to;
        w_rsp_err  = w_to;
        w_rsp_last = w_to;
        if (w_busy_rd && rd_ready) begin
            w_rsp_err  = rd_err;
            w_rsp_last = rd_last;
        end else if (w_busy_wr && wr_ready) begin
            w_rsp_err  = wr_err;
            w_rsp_last = 1'b1;
        end
    end

    always_comb begin
        m_ready = '0;
        m_err   = '0;
        m_last  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (r_gnt_idx == IDX_W'(i)) begin
                m_ready[i] = w_rsp_rdy;
                m_err[i]   = w_rsp_rdy && w_rsp_err;
                m_last[i]  = w_rsp_rdy && w_rsp_last;
            end
        end
    end

    assign m_rdata  = w_busy_rd ? rd_data : '0;
    assign rd_req   = w_busy_rd;
    assign rd_burst = r_cmd.burst;
    assign rd_len   = r_cmd.len;
    assign rd_addr  = r_cmd.addr[ADDR_W-1:0];
    assign wr_req   = w_busy_wr;
    assign wr_burst = r_cmd.burst;
    assign wr_len   = r_cmd.len;
    assign wr_mask  = r_cmd.mask;
    assign wr_addr  = r_cmd.addr[ADDR_W-1:0];
    assign wr_data  = r_cmd.wdata[LINE_W-1:0];
    assign gnt_idx  = r_gnt_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_wdog    <= '0;
            r_cmd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_cmd     <= w_pick_cmd;
                        r_gnt_idx <= w_pick_idx;
                        r_wdog    <= '0;
                        r_state   <= w_pick_cmd.wen ? BUSY_WR : BUSY_RD;
                    end
                end
                BUSY_RD, BUSY_WR: begin
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                        r_wdog   <= '0;
                    end else if (w_act_rdy) begin
                        r_wdog <= '0;
                    end else if (TIMEOUT > 0) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
